// File: rtl/clb_cfg_loader_pkg.sv
// Shared definitions for the CLB configuration loader: configuration vector layout,
// loader state encoding and the word-count helper.
package clb_cfg_pkg;

    localparam int CFG_BITS   = 150;

    localparam int BYP_LSB    = 0;
    localparam int BYP_W      = 16;
    localparam int SEL_LSB    = 16;
    localparam int SEL_W      = 96;
    localparam int SELOP_LSB  = 112;
    localparam int SELOP_W    = 32;
    localparam int SELOUT_LSB = 144;
    localparam int SELOUT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    // Number of stream words needed to cover the whole configuration vector.
    function automatic int num_words(input int word_w);
        return (CFG_BITS + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Word-stream handshake and status bundle between a configuration source and the loader.
interface clb_cfg_loader_if #(
    parameter int WORD_W = 16
);
    logic              cfg_start;
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready, busy, done, err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready, busy, done, err
    );
endinterface

// File: rtl/clb_cfg_loader.sv
// CLB configuration loader: assembles a 150-bit config in a shadow register and commits it atomically.
// Optional checksum word and CHECK state are enabled with CLB_CFG_CHECKSUM_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for cfg_start, cfg_ready low
// ST_LOAD   | accepting stream words into the shadow register
// ST_CHECK  | comparing received checksum with running XOR (macro only)
// ST_COMMIT | one cycle: shadow copied to active outputs, done pulsed
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    clb_cfg_loader_if.slave       bus,
    output logic [BYP_W-1:0]      bypass_all,
    output logic [SEL_W-1:0]      sel_all,
    output logic [SELOP_W-1:0]    selop_all,
    output logic [SELOUT_W-1:0]   selout_all
);

    localparam int NUM_WORDS = num_words(WORD_W);
`ifdef CLB_CFG_CHECKSUM_EN
    localparam int LAST_IDX  = NUM_WORDS;
`else
    localparam int LAST_IDX  = NUM_WORDS - 1;
`endif
    localparam int CNT_W     = $clog2(LAST_IDX + 1);

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt;
    logic [CFG_BITS-1:0]  shadow;
    logic [CFG_BITS-1:0]  active;
    logic                 xfer;
    logic                 last_word;
    logic                 ready_c;
    logic                 busy_c;
    logic                 done_c;

`ifdef CLB_CFG_CHECKSUM_EN
    logic [WORD_W-1:0]    xor_acc;
    logic [WORD_W-1:0]    chk_word;
    logic                 set_err;
    logic                 err_q;
`endif

    // cfg_start outranks a word offered in the same cycle: the load restarts and the word is dropped.
    assign xfer      = (state_q == ST_LOAD) && bus.cfg_valid && !bus.cfg_start;
    assign last_word = (cnt == CNT_W'(LAST_IDX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        busy_c  = 1'b1;
        done_c  = 1'b0;
`ifdef CLB_CFG_CHECKSUM_EN
        set_err = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready_c = 1'b1;
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                end else if (xfer && last_word) begin
`ifdef CLB_CFG_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
`ifdef CLB_CFG_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                end else if (chk_word == xor_acc) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                    set_err = 1'b1;
                end
            end
`endif
            ST_COMMIT: begin
                done_c  = 1'b1;
                state_d = bus.cfg_start ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Any cfg_start leads into a fresh LOAD, so the word counter restarts unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.cfg_start) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Word n lands at V[WORD_W*n +: WORD_W]; bits past the vector top are simply never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (xfer) begin
            for (int b = 0; b < CFG_BITS; b++) begin
                if (int'(cnt) == (b / WORD_W)) begin
                    shadow[b] <= bus.cfg_data[b % WORD_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
        end else if (state_q == ST_COMMIT) begin
            active <= shadow;
        end
    end

`ifdef CLB_CFG_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_acc  <= '0;
            chk_word <= '0;
        end else if (bus.cfg_start) begin
            xor_acc  <= '0;
        end else if (xfer) begin
            if (last_word) begin
                chk_word <= bus.cfg_data;
            end else begin
                xor_acc  <= xor_acc ^ bus.cfg_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.cfg_start) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.cfg_ready = ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;

    assign bypass_all = active[BYP_LSB    +: BYP_W];
    assign sel_all    = active[SEL_LSB    +: SEL_W];
    assign selop_all  = active[SELOP_LSB  +: SELOP_W];
    assign selout_all = active[SELOUT_LSB +: SELOUT_W];

endmodule
